// File: rtl/alu_ctrl_pkg.sv
// Shared ALU operation codes and execute-unit FSM encoding.
// The alu_control decoder imports the same codes so both sides agree.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH clocks.
// done/product are combinational on the last iteration so the caller can capture the final sum.
module seq_multiplier #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] counter;
    logic             running;
    logic [WIDTH-1:0] addend;

    assign addend  = multiplier[0] ? multiplicand : '0;
    assign product = acc + addend;
    assign done    = running && (counter == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multiplicand <= '0;
            multiplier   <= '0;
            acc          <= '0;
            counter      <= '0;
            running      <= 1'b0;
        end else if (start) begin
            multiplicand <= a;
            multiplier   <= b;
            acc          <= '0;
            counter      <= '0;
            running      <= 1'b1;
        end else if (running) begin
            acc          <= product;
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
            counter      <= counter + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops plus iterative MUL behind
// one valid/ready request port and one valid/ready result port.
module alu_exec_unit
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [1:0]       state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the source holds valid and payload stable until then.

    alu_state_e       state;
    alu_state_e       state_next;
    logic             accept;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;

    assign accept    = in_valid && in_ready;
    assign is_mul    = (alu_control == ALU_MUL);
    assign state_dbg = state;

    seq_multiplier #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (operand_a),
        .b       (operand_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = is_mul ? ST_BUSY : ST_DONE;
            ST_BUSY: if (mul_done) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    // Single-cycle datapath; unknown codes yield zero and flag illegal.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alu_control)
            ALU_AND: alu_res = operand_a & operand_b;
            ALU_OR:  alu_res = operand_a | operand_b;
            ALU_ADD: alu_res = operand_a + operand_b;
            ALU_SUB: alu_res = operand_a - operand_b;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            ALU_NOR: alu_res = ~(operand_a | operand_b);
            ALU_MUL: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            zero    <= 1'b1;
            illegal <= 1'b0;
        end else if (accept) begin
            illegal <= alu_ill;
            if (!is_mul) begin
                result <= alu_res;
                zero   <= (alu_res == '0);
            end
        end else if (state == ST_BUSY && mul_done) begin
            result <= mul_product;
            zero   <= (mul_product == '0);
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors checked with immediate assertions.
module tb_alu_exec_unit;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   alu_control = 4'b0000;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;
    logic [1:0]   state_dbg;

    int checks = 0;
    int failures = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .illegal     (illegal),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        check("in_ready_before_issue", W'(in_ready), W'(1));
        alu_control = code;
        operand_a   = a;
        operand_b   = b;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid    = 1'b0;
        operand_a   = ~a;
        operand_b   = ~b;
    endtask

    task automatic expect_result(input string tag, input logic [W-1:0] res, input logic z, input logic ill);
        check({tag, "_out_valid"}, W'(out_valid), W'(1));
        check({tag, "_result"}, result, res);
        check({tag, "_zero"}, W'(zero), W'(z));
        check({tag, "_illegal"}, W'(illegal), W'(ill));
        check({tag, "_in_ready"}, W'(in_ready), W'(0));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, W'(out_valid), W'(0));
        check({tag, "_in_ready_back"}, W'(in_ready), W'(1));
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_wait_valid"}, W'(out_valid), W'(1));
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_result", result, '0);
        check("rst_zero", W'(zero), W'(1));
        check("rst_illegal", W'(illegal), W'(0));
        check("rst_state", W'(state_dbg), W'(0));
        rst_n = 1'b1;

        // ADD with latency 1 and in_ready low until out_ready
        issue(4'b0010, 64'd5, 64'd7);
        expect_result("add", 64'd12, 1'b0, 1'b0);
        check("add_state_done", W'(state_dbg), W'(2));
        repeat (2) begin
            @(negedge clk);
            check("add_hold_in_ready", W'(in_ready), W'(0));
            check("add_hold_result", result, 64'd12);
        end
        release_result("add");

        // SUB to zero and wraparound
        issue(4'b0110, 64'd3, 64'd3);
        expect_result("sub_zero", 64'd0, 1'b1, 1'b0);
        release_result("sub_zero");
        issue(4'b0110, 64'd0, 64'd1);
        expect_result("sub_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        release_result("sub_wrap");

        // SLT signed, logic ops
        issue(4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        expect_result("slt_neg_lt_pos", 64'd1, 1'b0, 1'b0);
        release_result("slt_a");
        issue(4'b0111, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_result("slt_pos_lt_neg", 64'd0, 1'b1, 1'b0);
        release_result("slt_b");
        issue(4'b0000, 64'hF0, 64'h3C);
        expect_result("and", 64'h30, 1'b0, 1'b0);
        release_result("and");
        issue(4'b0001, 64'hF0, 64'h3C);
        expect_result("or", 64'hFC, 1'b0, 1'b0);
        release_result("or");
        issue(4'b1100, 64'd0, 64'd0);
        expect_result("nor", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        release_result("nor");

        // MUL exact latency; out_ready and in_valid asserted during BUSY must not matter
        issue(4'b1000, 64'd6, 64'd7);
        out_ready = 1'b1;
        alu_control = 4'b0010;
        for (int i = 0; i < 64; i++) begin
            check("mul_not_yet_valid", W'(out_valid), W'(0));
            in_valid = (i % 2 == 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        expect_result("mul_6x7", 64'd42, 1'b0, 1'b0);
        release_result("mul_6x7");

        issue(4'b1000, 64'h8000_0000_0000_0000, 64'd2);
        wait_valid("mul_trunc", 100);
        expect_result("mul_trunc", 64'd0, 1'b1, 1'b0);
        release_result("mul_trunc");

        // Backpressure: result stays put, request pulses ignored
        issue(4'b0010, 64'd1, 64'd2);
        for (int i = 0; i < 10; i++) begin
            alu_control = 4'b0001;
            operand_a   = 64'(i + 100);
            in_valid    = (i % 2 == 1);
            @(negedge clk);
            check("bp_out_valid", W'(out_valid), W'(1));
            check("bp_result", result, 64'd3);
            check("bp_in_ready", W'(in_ready), W'(0));
        end
        in_valid = 1'b0;
        release_result("bp");
        check("bp_state_idle", W'(state_dbg), W'(0));

        // Illegal code, then cleared by a legal op
        issue(4'b1111, 64'd9, 64'd9);
        expect_result("illegal", 64'd0, 1'b1, 1'b1);
        release_result("illegal");
        issue(4'b0010, 64'd10, 64'd20);
        expect_result("illegal_clear", 64'd30, 1'b0, 1'b0);
        release_result("illegal_clear");

        // Asynchronous reset in the middle of a MUL
        issue(4'b1000, 64'd6, 64'd7);
        repeat (19) @(negedge clk);
        check("abort_state_busy", W'(state_dbg), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", W'(in_ready), W'(1));
        check("abort_out_valid", W'(out_valid), W'(0));
        check("abort_result", result, '0);
        check("abort_zero", W'(zero), W'(1));
        check("abort_illegal", W'(illegal), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'b0010, 64'd5, 64'd7);
        expect_result("post_abort_add", 64'd12, 1'b0, 1'b0);
        release_result("post_abort_add");
        repeat (70) begin
            @(negedge clk);
            check("post_abort_no_stray_valid", W'(out_valid), W'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
